// File: rtl/event_enc_pkg.sv
// Shared types and pick helpers for the 8-to-3 event encoder.
package event_enc_pkg;

  localparam int unsigned N_EVT = 8;
  localparam int unsigned IDX_W = 3;

  typedef logic [IDX_W-1:0] evt_idx_t;
  typedef logic [N_EVT-1:0] evt_vec_t;

  // Lowest set index; returns 0 when cand is empty (caller gates on |cand).
  function automatic evt_idx_t pick_fixed(evt_vec_t cand);
    evt_idx_t idx;
    idx = '0;
    for (int i = int'(N_EVT) - 1; i >= 0; i--) begin
      if (cand[i]) idx = evt_idx_t'(i);
    end
    return idx;
  endfunction

  // First set index at ptr, ptr+1, ... wrapping; rotate so ptr lands at bit 0.
  function automatic evt_idx_t pick_rr(evt_vec_t cand, evt_idx_t ptr);
    evt_vec_t rot;
    rot = evt_vec_t'({cand, cand} >> ptr);
    return evt_idx_t'(pick_fixed(rot) + ptr);
  endfunction

endpackage

// File: rtl/decoder_3_to_8.sv
// One-hot decode of an event index, gated by ena.
module decoder_3_to_8
  import event_enc_pkg::*;
(
  input  logic     ena,
  input  evt_idx_t idx,
  output evt_vec_t onehot_c
);

  always_comb begin
    onehot_c = '0;
    if (ena) onehot_c[idx] = 1'b1;
  end

endmodule

// File: rtl/event_encoder_8_to_3.sv
// Sticky event collector presenting one pending event index at a time on valid/ready.
module event_encoder_8_to_3
  import event_enc_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     ena,
  input  logic     clr,
  input  evt_vec_t req,
  input  logic     out_ready,
  output logic     out_valid,
  output evt_idx_t out_idx,
  output evt_vec_t pending,
  output logic     overflow
);

  evt_vec_t pending_q, pending_d;
  evt_idx_t rr_ptr, rr_ptr_d;
  evt_idx_t out_idx_d;
  logic     out_valid_d, overflow_d;

  evt_vec_t pres_mask_c, clr_mask_c, set_mask_c, cand_c;
  logic     hs_c, load_c;

  // Mask of the currently presented event; empty when nothing is presented.
  decoder_3_to_8 u_dec (
    .ena      (out_valid),
    .idx      (out_idx),
    .onehot_c (pres_mask_c)
  );

  // Next-state: set wins over handshake clear; clr flushes everything but out_idx.
  always_comb begin
    hs_c        = out_valid & out_ready;
    clr_mask_c  = pres_mask_c & {N_EVT{out_ready}};
    set_mask_c  = ena ? req : '0;
    cand_c      = pending_q & ~pres_mask_c;
    load_c      = ~out_valid | hs_c;

    pending_d   = (pending_q & ~clr_mask_c) | set_mask_c;
    overflow_d  = |(set_mask_c & pending_q & ~clr_mask_c);
    out_valid_d = out_valid;
    out_idx_d   = out_idx;
    rr_ptr_d    = rr_ptr;

    if (load_c) begin
      out_valid_d = |cand_c;
      if (|cand_c) begin
        out_idx_d = (ROUND_ROBIN != 0) ? pick_rr(cand_c, rr_ptr) : pick_fixed(cand_c);
      end
    end
    if (hs_c) rr_ptr_d = evt_idx_t'(out_idx + evt_idx_t'(1));

    if (clr) begin
      pending_d   = '0;
      overflow_d  = 1'b0;
      out_valid_d = 1'b0;
      out_idx_d   = out_idx;
      rr_ptr_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      rr_ptr    <= '0;
      overflow  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      out_valid <= out_valid_d;
      out_idx   <= out_idx_d;
      rr_ptr    <= rr_ptr_d;
      overflow  <= overflow_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: tb/tb_event_encoder_8_to_3.sv
// Bench for event_encoder_8_to_3: round-robin and fixed-priority instances on shared stimulus,
// a per-cycle behavioural model plus directed literal expectations.
module tb_event_encoder_8_to_3;

  logic       clk, rst_n, ena, clr, out_ready;
  logic [7:0] req;

  logic       v_rr, v_fx, o_rr, o_fx;
  logic [2:0] i_rr, i_fx;
  logic [7:0] p_rr, p_fx;

  int checks = 0;
  int errors = 0;

  event_encoder_8_to_3 #(.ROUND_ROBIN(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .req(req), .out_ready(out_ready),
    .out_valid(v_rr), .out_idx(i_rr), .pending(p_rr), .overflow(o_rr)
  );

  event_encoder_8_to_3 #(.ROUND_ROBIN(0)) u_fx (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .req(req), .out_ready(out_ready),
    .out_valid(v_fx), .out_idx(i_fx), .pending(p_fx), .overflow(o_fx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Behavioural model: a set of pending event numbers and the presented one.
  typedef struct {
    bit pend [8];
    bit val;
    int idx;
    int ptr;
    bit ovf;
  } mdl_t;

  mdl_t m_fx, m_rr;

  function automatic mdl_t mstep(mdl_t s, bit rr, bit e, bit c, logic [7:0] r, bit rdy);
    mdl_t n;
    bit   accepted;
    n = s;
    if (c) begin
      foreach (n.pend[k]) n.pend[k] = 1'b0;
      n.val = 1'b0;
      n.ptr = 0;
      n.ovf = 1'b0;
      return n;
    end
    accepted = s.val && rdy;
    n.ovf = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bit taken, raised;
      taken  = accepted && (s.idx == k);
      raised = e && r[k];
      if (raised && s.pend[k] && !taken) n.ovf = 1'b1;
      n.pend[k] = (s.pend[k] && !taken) || raised;
    end
    if (!s.val || accepted) begin
      n.val = 1'b0;
      for (int k = 0; k < 8; k++) begin
        int j;
        j = rr ? (s.ptr + k) % 8 : k;
        if (!n.val && s.pend[j] && !(s.val && s.idx == j)) begin
          n.val = 1'b1;
          n.idx = j;
        end
      end
    end
    if (accepted) n.ptr = (s.idx + 1) % 8;
    return n;
  endfunction

  function automatic mdl_t mreset();
    mdl_t n;
    foreach (n.pend[k]) n.pend[k] = 1'b0;
    n.val = 1'b0;
    n.idx = 0;
    n.ptr = 0;
    n.ovf = 1'b0;
    return n;
  endfunction

  function automatic logic [7:0] mvec(mdl_t s);
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = s.pend[k];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fx <= mreset();
      m_rr <= mreset();
    end else begin
      m_fx <= mstep(m_fx, 1'b0, ena, clr, req, out_ready);
      m_rr <= mstep(m_rr, 1'b1, ena, clr, req, out_ready);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rr_valid", 32'(v_rr), 32'(m_rr.val));
      chk("rr_pending", 32'(p_rr), 32'(mvec(m_rr)));
      chk("rr_overflow", 32'(o_rr), 32'(m_rr.ovf));
      if (m_rr.val) chk("rr_idx", 32'(i_rr), 32'(m_rr.idx));
      chk("fx_valid", 32'(v_fx), 32'(m_fx.val));
      chk("fx_pending", 32'(p_fx), 32'(mvec(m_fx)));
      chk("fx_overflow", 32'(o_fx), 32'(m_fx.ovf));
      if (m_fx.val) chk("fx_idx", 32'(i_fx), 32'(m_fx.idx));
    end
  end

  task automatic cyc(input logic [7:0] r, input logic rdy);
    req = r;
    out_ready = rdy;
    @(posedge clk);
    #2;
  endtask

  task automatic exp_both(string name, logic v, logic [2:0] i_r, logic [2:0] i_f, logic [7:0] p, logic o);
    chk({name, "_rr_v"}, 32'(v_rr), 32'(v));
    chk({name, "_fx_v"}, 32'(v_fx), 32'(v));
    if (v) begin
      chk({name, "_rr_i"}, 32'(i_rr), 32'(i_r));
      chk({name, "_fx_i"}, 32'(i_fx), 32'(i_f));
    end
    chk({name, "_rr_p"}, 32'(p_rr), 32'(p));
    chk({name, "_fx_p"}, 32'(p_fx), 32'(p));
    chk({name, "_rr_o"}, 32'(o_rr), 32'(o));
    chk({name, "_fx_o"}, 32'(o_fx), 32'(o));
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; clr = 1'b0; req = '0; out_ready = 1'b0;
    #22 rst_n = 1'b1;
    #1;
    exp_both("reset", 1'b0, 3'd0, 3'd0, 8'h00, 1'b0);
    chk("reset_rr_idx", 32'(i_rr), 32'd0);

    // Single event: two edges to presentation, gone after the handshake.
    cyc(8'h10, 1'b1);  exp_both("single_p", 1'b0, 3'd0, 3'd0, 8'h10, 1'b0);
    cyc(8'h00, 1'b1);  exp_both("single_v", 1'b1, 3'd4, 3'd4, 8'h10, 1'b0);
    cyc(8'h00, 1'b1);  exp_both("single_e", 1'b0, 3'd0, 3'd0, 8'h00, 1'b0);

    // Async reset while an event is presented and stalled.
    cyc(8'h01, 1'b0);
    cyc(8'h00, 1'b0);  exp_both("pre_rst", 1'b1, 3'd0, 3'd0, 8'h01, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    exp_both("async_rst", 1'b0, 3'd0, 3'd0, 8'h00, 1'b0);
    chk("async_rst_idx", 32'(i_rr), 32'd0);
    #4 rst_n = 1'b1;

    // All eight at once drain in index order.
    cyc(8'hFF, 1'b1);  exp_both("ff_p", 1'b0, 3'd0, 3'd0, 8'hFF, 1'b0);
    for (int k = 0; k < 8; k++) begin
      cyc(8'h00, 1'b1);
      chk("ff_seq_rr", 32'(i_rr), 32'(k));
      chk("ff_seq_fx", 32'(i_fx), 32'(k));
    end
    cyc(8'h00, 1'b1);  exp_both("ff_end", 1'b0, 3'd0, 3'd0, 8'h00, 1'b0);

    cyc(8'h81, 1'b1);
    cyc(8'h00, 1'b1);  exp_both("e81_a", 1'b1, 3'd0, 3'd0, 8'h81, 1'b0);
    cyc(8'h00, 1'b1);  exp_both("e81_b", 1'b1, 3'd7, 3'd7, 8'h80, 1'b0);
    cyc(8'h00, 1'b1);  exp_both("e81_c", 1'b0, 3'd0, 3'd0, 8'h00, 1'b0);

    // Re-raised bit 0: fixed priority takes it before 7, round-robin does not.
    cyc(8'h83, 1'b1);
    cyc(8'h00, 1'b1);  exp_both("pre_a", 1'b1, 3'd0, 3'd0, 8'h83, 1'b0);
    cyc(8'h01, 1'b1);  exp_both("pre_b", 1'b1, 3'd1, 3'd1, 8'h83, 1'b0);
    cyc(8'h00, 1'b1);  exp_both("pre_c", 1'b1, 3'd7, 3'd0, 8'h81, 1'b0);
    cyc(8'h00, 1'b1);
    chk("pre_d_rr", 32'(i_rr), 32'd0);
    chk("pre_d_fx", 32'(i_fx), 32'd7);
    cyc(8'h00, 1'b1);  exp_both("pre_e", 1'b0, 3'd0, 3'd0, 8'h00, 1'b0);

    // Backpressure holds the presented index.
    cyc(8'h06, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cyc(8'h00, 1'b0);
      exp_both("bp_hold", 1'b1, 3'd1, 3'd1, 8'h06, 1'b0);
    end
    cyc(8'h00, 1'b1);  exp_both("bp_rel", 1'b1, 3'd2, 3'd2, 8'h04, 1'b0);
    cyc(8'h00, 1'b1);  exp_both("bp_end", 1'b0, 3'd0, 3'd0, 8'h00, 1'b0);

    // Collision on a pending, not presented bit pulses overflow once.
    cyc(8'h01, 1'b0);
    cyc(8'h08, 1'b0);  exp_both("ov_a", 1'b1, 3'd0, 3'd0, 8'h09, 1'b0);
    cyc(8'h08, 1'b0);  exp_both("ov_b", 1'b1, 3'd0, 3'd0, 8'h09, 1'b1);
    cyc(8'h00, 1'b0);  exp_both("ov_c", 1'b1, 3'd0, 3'd0, 8'h09, 1'b0);
    cyc(8'h00, 1'b1);  exp_both("ov_d", 1'b1, 3'd3, 3'd3, 8'h08, 1'b0);
    cyc(8'h08, 1'b1);  exp_both("ov_e", 1'b0, 3'd0, 3'd0, 8'h08, 1'b0);
    cyc(8'h00, 1'b1);  exp_both("ov_f", 1'b1, 3'd3, 3'd3, 8'h08, 1'b0);
    cyc(8'h00, 1'b1);  exp_both("ov_g", 1'b0, 3'd0, 3'd0, 8'h00, 1'b0);

    // clr drops a presented event and beats req; ena=0 masks req.
    cyc(8'h02, 1'b0);
    cyc(8'h00, 1'b0);  exp_both("clr_pre", 1'b1, 3'd1, 3'd1, 8'h02, 1'b0);
    clr = 1'b1;
    cyc(8'hFF, 1'b1);  exp_both("clr", 1'b0, 3'd0, 3'd0, 8'h00, 1'b0);
    chk("clr_idx_hold_rr", 32'(i_rr), 32'd1);
    clr = 1'b0;
    ena = 1'b0;
    cyc(8'hFF, 1'b1);  exp_both("ena0_a", 1'b0, 3'd0, 3'd0, 8'h00, 1'b0);
    cyc(8'hFF, 1'b0);  exp_both("ena0_b", 1'b0, 3'd0, 3'd0, 8'h00, 1'b0);
    ena = 1'b1;

    // Full: every bit pending, repeat of all eight merges.
    cyc(8'hFF, 1'b0);  exp_both("full_a", 1'b0, 3'd0, 3'd0, 8'hFF, 1'b0);
    cyc(8'hFF, 1'b0);  exp_both("full_b", 1'b1, 3'd0, 3'd0, 8'hFF, 1'b1);
    clr = 1'b1;
    cyc(8'h00, 1'b0);  exp_both("full_clr", 1'b0, 3'd0, 3'd0, 8'h00, 1'b0);
    clr = 1'b0;
    cyc(8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
